// File: rtl/riscv_test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : riscv_test_monitor
// Purpose  : Snoops the register-file writeback port of a RISC-V core and
//            judges riscv-tests style programs. It waits for the done
//            register to be written with 1, lets a settle window elapse,
//            then latches a PASS/FAIL verdict. A watchdog declares TIMEOUT
//            if done never arrives.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_test_monitor #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned DONE_REG       = 26,
  parameter int unsigned RESULT_REG     = 27,
  parameter int unsigned TESTNUM_REG    = 3,
  parameter int unsigned SETTLE_CYCLES  = 100,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [XLEN-1:0] fail_testnum,
  output logic [31:0]     cycle_count
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_SETTLE  = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam logic [4:0]      DONE_IDX    = 5'(DONE_REG);
  localparam logic [4:0]      RESULT_IDX  = 5'(RESULT_REG);
  localparam logic [4:0]      TESTNUM_IDX = 5'(TESTNUM_REG);
  localparam logic [31:0]     SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  // Guarded so a disabled watchdog does not produce a wrapped compare value.
  localparam logic [31:0]     TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0
                                                                   : 32'(TIMEOUT_CYCLES - 1);
  localparam logic            TIMEOUT_ON  = (TIMEOUT_CYCLES != 0);
  localparam logic [XLEN-1:0] ONE         = XLEN'(1);
  localparam logic [31:0]     CNT_MAX     = 32'hFFFF_FFFF;

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] res_sh;
  logic [XLEN-1:0] tn_sh;
  logic [31:0]     settle_cnt;

  logic            active;
  logic            wr_valid;
  logic            wr_done;
  logic            wr_result;
  logic            wr_testnum;
  logic [XLEN-1:0] eff_result;
  logic [XLEN-1:0] eff_testnum;
  logic            enter_fail;

  // Snooped writes only matter while a test is still running; x0 is never a target.
  assign active      = (state == S_RUN) || (state == S_SETTLE);
  assign wr_valid    = wb_en && (wb_addr != 5'd0) && active;
  assign wr_done     = wr_valid && (wb_addr == DONE_IDX);
  assign wr_result   = wr_valid && (wb_addr == RESULT_IDX);
  assign wr_testnum  = wr_valid && (wb_addr == TESTNUM_IDX);

  // Same-cycle forwarding so a write landing on the verdict edge still counts.
  assign eff_result  = wr_result  ? wb_data : res_sh;
  assign eff_testnum = wr_testnum ? wb_data : tn_sh;

  assign enter_fail  = active && ((state_next == S_FAIL) || (state_next == S_TIMEOUT));

  // Next-state logic; clear overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      S_RUN: begin
        if (wr_done && (wb_data == ONE)) begin
          state_next = S_SETTLE;
        end else if (TIMEOUT_ON && (cycle_count == TIMEOUT_LAST)) begin
          state_next = S_TIMEOUT;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = (eff_result == ONE) ? S_PASS : S_FAIL;
        end
      end
      default: state_next = state;
    endcase
    if (clear) begin
      state_next = S_RUN;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Result and test-number shadows of the snooped register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_sh <= '0;
      tn_sh  <= '0;
    end else if (clear) begin
      res_sh <= '0;
      tn_sh  <= '0;
    end else begin
      if (wr_result) begin
        res_sh <= wb_data;
      end
      if (wr_testnum) begin
        tn_sh <= wb_data;
      end
    end
  end

  // Settle counter: held at zero in RUN, counts through SETTLE, frozen afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt <= '0;
    end else if (clear || (state == S_RUN)) begin
      settle_cnt <= '0;
    end else if (state == S_SETTLE) begin
      settle_cnt <= settle_cnt + 32'd1;
    end
  end

  // Saturating run-time counter covering RUN and SETTLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
    end else if (clear) begin
      cycle_count <= '0;
    end else if (active && (cycle_count != CNT_MAX)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // Failing test number is captured once, on entry to FAIL or TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_testnum <= '0;
    end else if (clear) begin
      fail_testnum <= '0;
    end else if (enter_fail) begin
      fail_testnum <= eff_testnum;
    end
  end

  // Verdict flags decode the state register only.
  assign done    = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);
  assign pass    = (state == S_PASS);
  assign fail    = (state == S_FAIL) || (state == S_TIMEOUT);
  assign timeout = (state == S_TIMEOUT);

endmodule
`default_nettype wire

// File: tb/tb_riscv_test_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_riscv_test_monitor
// Purpose  : Directed bench for riscv_test_monitor. Three instances share the
//            stimulus: a 64-bit monitor with the watchdog disabled, a 64-bit
//            monitor with a 50-cycle watchdog and a 32-bit monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_test_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [63:0] wb_data = 64'd0;

  logic        m_done, m_pass, m_fail, m_timeout;
  logic [63:0] m_tn;
  logic [31:0] m_cc;
  logic        t_done, t_pass, t_fail, t_timeout;
  logic [63:0] t_tn;
  logic [31:0] t_cc;
  logic        s_done, s_pass, s_fail, s_timeout;
  logic [31:0] s_tn;
  logic [31:0] s_cc;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  riscv_test_monitor #(.XLEN(64), .SETTLE_CYCLES(100), .TIMEOUT_CYCLES(0)) u_main (
    .clk(clk), .rst(rst), .clear(clear), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .done(m_done), .pass(m_pass), .fail(m_fail),
    .timeout(m_timeout), .fail_testnum(m_tn), .cycle_count(m_cc));

  riscv_test_monitor #(.XLEN(64), .SETTLE_CYCLES(100), .TIMEOUT_CYCLES(50)) u_to (
    .clk(clk), .rst(rst), .clear(clear), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .done(t_done), .pass(t_pass), .fail(t_fail),
    .timeout(t_timeout), .fail_testnum(t_tn), .cycle_count(t_cc));

  riscv_test_monitor #(.XLEN(32), .SETTLE_CYCLES(100), .TIMEOUT_CYCLES(0)) u_32 (
    .clk(clk), .rst(rst), .clear(clear), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data[31:0]), .done(s_done), .pass(s_pass), .fail(s_fail),
    .timeout(s_timeout), .fail_testnum(s_tn), .cycle_count(s_cc));

  // Advance n rising edges, leaving time 1ns past the last one.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One writeback sampled at the next rising edge.
  task automatic wb(input logic [4:0] a, input logic [63:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    idle(1);
    wb_en   = 1'b0;
    wb_addr = 5'd0;
    wb_data = 64'd0;
  endtask

  // Reset all instances; the next rising edge is edge 1.
  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({m_done, m_pass, m_fail, m_timeout} !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", {m_done, m_pass, m_fail, m_timeout});
    else passed++;
    total++;
    if (m_tn !== 64'd0 || m_cc !== 32'd0) $display("FAIL reset_regs got tn=%0h cc=%0d exp 0/0", m_tn, m_cc);
    else passed++;
  endtask

  task automatic test_pass();
    do_reset();
    idle(8);
    wb(5'd27, 64'd1);          // edge 9
    wb(5'd26, 64'd1);          // edge 10
    idle(99);                  // edge 109
    total++;
    if (m_done !== 1'b0) $display("FAIL pass_early_done got=%b exp=0", m_done);
    else passed++;
    idle(1);                   // edge 110
    total++;
    if ({m_done, m_pass, m_fail, m_timeout} !== 4'b1100) $display("FAIL pass_flags got=%b exp=1100", {m_done, m_pass, m_fail, m_timeout});
    else passed++;
    total++;
    if (m_tn !== 64'd0 || m_cc !== 32'd110) $display("FAIL pass_regs got tn=%0h cc=%0d exp 0/110", m_tn, m_cc);
    else passed++;
    total++;
    if (s_pass !== 1'b1) $display("FAIL pass_x32 got=%b exp=1", s_pass);
    else passed++;
    wb(5'd27, 64'd0);          // late result write must not disturb PASS
    idle(5);
    total++;
    if ({m_done, m_pass, m_fail} !== 3'b110 || m_cc !== 32'd110) $display("FAIL pass_sticky got=%b cc=%0d exp=110 cc=110", {m_done, m_pass, m_fail}, m_cc);
    else passed++;
  endtask

  task automatic test_fail();
    do_reset();
    wb(5'd3, 64'hA000_0000_0000_0005);
    wb(5'd27, 64'h0B);
    wb(5'd26, 64'd1);          // edge 3
    idle(100);                 // edge 103
    total++;
    if ({m_done, m_pass, m_fail, m_timeout} !== 4'b1010) $display("FAIL fail_flags got=%b exp=1010", {m_done, m_pass, m_fail, m_timeout});
    else passed++;
    total++;
    if (m_tn !== 64'hA000_0000_0000_0005) $display("FAIL fail_testnum got=%0h exp=a000000000000005", m_tn);
    else passed++;
    total++;
    if ({s_done, s_pass, s_fail} !== 3'b101 || s_tn !== 32'd5) $display("FAIL fail_x32 got=%b tn=%0h exp=101 tn=5", {s_done, s_pass, s_fail}, s_tn);
    else passed++;
  endtask

  task automatic test_clear();
    // Monitor is in FAIL; clear arrives together with a result write that must be dropped.
    clear   = 1'b1;
    wb(5'd27, 64'd1);
    clear   = 1'b0;
    total++;
    if ({m_done, m_pass, m_fail, m_timeout} !== 4'b0000 || m_tn !== 64'd0 || m_cc !== 32'd0)
      $display("FAIL clear_outputs got=%b tn=%0h cc=%0d exp=0000 0 0", {m_done, m_pass, m_fail, m_timeout}, m_tn, m_cc);
    else passed++;
    wb(5'd26, 64'd1);          // accepted in the cycle right after clear
    idle(100);
    total++;
    if ({m_done, m_pass, m_fail} !== 3'b101 || m_tn !== 64'd0) $display("FAIL clear_dropped_wb got=%b tn=%0h exp=101 tn=0", {m_done, m_pass, m_fail}, m_tn);
    else passed++;
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    wb(5'd27, 64'd1);
    wb(5'd26, 64'd1);
    idle(100);
    total++;
    if ({m_done, m_pass, m_fail} !== 3'b110) $display("FAIL clear_rerun_pass got=%b exp=110", {m_done, m_pass, m_fail});
    else passed++;
  endtask

  task automatic test_forward();
    do_reset();
    wb(5'd26, 64'd1);          // edge 1, verdict at edge 101
    idle(99);                  // edge 100
    wb(5'd27, 64'd1);          // edge 101 (forwarded)
    total++;
    if ({m_done, m_pass, m_fail} !== 3'b110) $display("FAIL fwd_on_verdict got=%b exp=110", {m_done, m_pass, m_fail});
    else passed++;
    do_reset();
    wb(5'd26, 64'd1);          // edge 1
    idle(100);                 // edge 101 verdict
    wb(5'd27, 64'd1);          // edge 102, too late
    total++;
    if ({m_done, m_pass, m_fail} !== 3'b101) $display("FAIL fwd_too_late got=%b exp=101", {m_done, m_pass, m_fail});
    else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    wb(5'd3, 64'd9);           // edge 1
    idle(48);                  // edge 49
    total++;
    if (t_timeout !== 1'b0 || t_done !== 1'b0) $display("FAIL to_early got=%b%b exp=00", t_timeout, t_done);
    else passed++;
    idle(1);                   // edge 50
    total++;
    if ({t_done, t_pass, t_fail, t_timeout} !== 4'b1011 || t_cc !== 32'd50 || t_tn !== 64'd9)
      $display("FAIL to_fire got=%b cc=%0d tn=%0h exp=1011 cc=50 tn=9", {t_done, t_pass, t_fail, t_timeout}, t_cc, t_tn);
    else passed++;
    idle(30);                  // edge 80
    total++;
    if (m_timeout !== 1'b0 || m_done !== 1'b0 || m_cc !== 32'd80 || t_cc !== 32'd50)
      $display("FAIL to_disabled got to=%b done=%b cc=%0d tcc=%0d exp 0 0 80 50", m_timeout, m_done, m_cc, t_cc);
    else passed++;
    do_reset();
    idle(49);
    wb(5'd26, 64'd1);          // edge 50: done wins over the watchdog
    total++;
    if (t_timeout !== 1'b0 || t_done !== 1'b0) $display("FAIL to_done_wins got=%b%b exp=00", t_timeout, t_done);
    else passed++;
    idle(100);                 // edge 150 verdict
    total++;
    if ({t_done, t_pass, t_fail, t_timeout} !== 4'b1010) $display("FAIL to_done_verdict got=%b exp=1010", {t_done, t_pass, t_fail, t_timeout});
    else passed++;
  endtask

  task automatic test_edge_cases();
    do_reset();
    wb(5'd26, 64'd2);
    wb(5'd0, 64'd1);
    wb(5'd26, 64'h1_0000_0001);
    idle(110);
    total++;
    if (m_done !== 1'b0 || m_cc !== 32'd113) $display("FAIL edge_not_done got done=%b cc=%0d exp 0 113", m_done, m_cc);
    else passed++;
    wb(5'd27, 64'd1);
    wb(5'd26, 64'd1);
    idle(100);
    total++;
    if ({m_done, m_pass, m_fail} !== 3'b110) $display("FAIL edge_then_pass got=%b exp=110", {m_done, m_pass, m_fail});
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    wb(5'd27, 64'd1);
    wb(5'd26, 64'd1);          // edge 2
    idle(20);                  // SETTLE, cycle_count 22
    #2;
    rst = 1'b0;
    #1;                        // no clock edge in between
    total++;
    if (m_cc !== 32'd0 || m_done !== 1'b0) $display("FAIL async_rst got cc=%0d done=%b exp 0 0", m_cc, m_done);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wb(5'd26, 64'd1);          // result shadow was wiped, so this must fail
    idle(100);
    total++;
    if ({m_done, m_pass, m_fail} !== 3'b101) $display("FAIL async_rst_restart got=%b exp=101", {m_done, m_pass, m_fail});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_clear();
    test_forward();
    test_timeout();
    test_edge_cases();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
